// File: rtl/ts_bus_pkg.sv
// Shared types and constants for the muxed slave-bus master.
// Includes the saturating error-counter increment used by ts_bus_ctrl.
package ts_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } ts_bus_state_e;

    typedef enum logic [1:0] {
        TS_OK      = 2'd0,
        TS_DECERR  = 2'd1,
        TS_TIMEOUT = 2'd2
    } ts_bus_status_e;

    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == {ERR_CNT_W{1'b1}}) ? cnt : cnt + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ts_bus_decode.sv
// Combinational slave decode: upper SEL_W address bits select a slave.
// Indices at or above N_SLV are reported unmapped with an all-zero select.
module ts_bus_decode #(
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 2,
    parameter int N_SLV  = 4
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_mapped,
    output logic [N_SLV-1:0]  o_sel
);

    localparam logic [SEL_W:0] N_SLV_L = (SEL_W+1)'(N_SLV);

    logic [SEL_W-1:0] w_idx;

    assign w_idx    = i_addr[ADDR_W-1 -: SEL_W];
    assign o_mapped = ({1'b0, w_idx} < N_SLV_L);

    if (ADDR_W > SEL_W) begin : g_lo
        logic w_unused_lo;
        assign w_unused_lo = ^i_addr[ADDR_W-SEL_W-1:0];
    end

    // One-hot select, forced to zero for unmapped indices
    always_comb begin
        o_sel = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (o_mapped && (w_idx == SEL_W'(i))) begin
                o_sel[i] = 1'b1;
            end else begin
                o_sel[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ts_bus_ctrl.sv
// Single-outstanding master for the shared addressed slave bus: decode,
// one-hot select, ack wait with timeout, and a held response with status.
module ts_bus_ctrl
    import ts_bus_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 2,
    parameter int N_SLV   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic [1:0]              rsp_status,
    output logic [ADDR_W-1:0]       bus_adrs,
    output logic [N_SLV-1:0]        bus_sel,
    output logic                    bus_we,
    output logic [DATA_W-1:0]       bus_wdata,
    input  logic [N_SLV-1:0]        slv_ack,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    ts_bus_state_e        r_state;
    ts_bus_state_e        w_state_nxt;
    ts_bus_status_e       r_rsp_status;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic [ADDR_W-1:0]    r_bus_adrs;
    logic [N_SLV-1:0]     r_bus_sel;
    logic                 r_bus_we;
    logic [DATA_W-1:0]    r_bus_wdata;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_dec_mapped;
    logic [N_SLV-1:0]     w_dec_sel;
    logic                 w_ack_hit;
    logic                 w_cnt_done;
    logic [DATA_W-1:0]    w_rd_mux;

    ts_bus_decode #(
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W),
        .N_SLV  (N_SLV)
    ) u_decode (
        .i_addr   (req_addr),
        .o_mapped (w_dec_mapped),
        .o_sel    (w_dec_sel)
    );

    // r_bus_sel is the latched target while in BUS and zero otherwise, so it masks stray acks
    assign w_ack_hit  = |(slv_ack & r_bus_sel);
    assign w_cnt_done = (r_cnt == CNT_W'(TIMEOUT));

    // Read-data mux driven by the latched one-hot select
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < N_SLV; i++) begin
            w_rd_mux = w_rd_mux | (slv_rdata[i*DATA_W +: DATA_W] & {DATA_W{r_bus_sel[i]}});
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = w_dec_mapped ? BUS : RESP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUS: begin
                if (w_ack_hit || w_cnt_done) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = BUS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered bus, response and error-count outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_status <= TS_OK;
            r_bus_adrs   <= '0;
            r_bus_sel    <= '0;
            r_bus_we     <= 1'b0;
            r_bus_wdata  <= '0;
            r_err_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_bus_adrs  <= req_addr;
                        r_bus_wdata <= req_wdata;
                        r_cnt       <= '0;
                        if (w_dec_mapped) begin
                            r_bus_sel <= w_dec_sel;
                            r_bus_we  <= req_write;
                        end else begin
                            r_bus_sel    <= '0;
                            r_bus_we     <= 1'b0;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_rdata  <= '0;
                            r_rsp_status <= TS_DECERR;
                        end
                    end
                end
                BUS: begin
                    // An ack in the final wait cycle takes precedence over the timeout
                    if (w_ack_hit) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= r_bus_we ? '0 : w_rd_mux;
                        r_rsp_status <= TS_OK;
                        r_bus_sel    <= '0;
                        r_bus_we     <= 1'b0;
                    end else if (w_cnt_done) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= '0;
                        r_rsp_status <= TS_TIMEOUT;
                        r_bus_sel    <= '0;
                        r_bus_we     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        if (r_rsp_status != TS_OK) begin
                            r_err_cnt <= err_cnt_inc(r_err_cnt);
                        end
                    end
                end
                default: begin
                    r_bus_sel   <= '0;
                    r_bus_we    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_status = r_rsp_status;
    assign bus_adrs   = r_bus_adrs;
    assign bus_sel    = r_bus_sel;
    assign bus_we     = r_bus_we;
    assign bus_wdata  = r_bus_wdata;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_ts_bus_ctrl.sv
// Self-checking bench for ts_bus_ctrl: directed vector table, randomized
// transactions against a latency/status model, saturation, reset and DECERR.
module tb_ts_bus_ctrl;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int SEL_W   = 2;
    localparam int N_SLV   = 4;
    localparam int N_SLV3  = 3;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n;

    logic                    req_valid, req_ready, req_write;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_wdata;
    logic                    rsp_valid, rsp_ready;
    logic [DATA_W-1:0]       rsp_rdata;
    logic [1:0]              rsp_status;
    logic [ADDR_W-1:0]       bus_adrs;
    logic [N_SLV-1:0]        bus_sel;
    logic                    bus_we;
    logic [DATA_W-1:0]       bus_wdata;
    logic [N_SLV-1:0]        slv_ack;
    logic [N_SLV*DATA_W-1:0] slv_rdata;
    logic [7:0]              err_cnt;

    logic                     req_valid3, req_ready3, req_write3;
    logic [ADDR_W-1:0]        req_addr3;
    logic [DATA_W-1:0]        req_wdata3;
    logic                     rsp_valid3, rsp_ready3;
    logic [DATA_W-1:0]        rsp_rdata3;
    logic [1:0]               rsp_status3;
    logic [ADDR_W-1:0]        bus_adrs3;
    logic [N_SLV3-1:0]        bus_sel3;
    logic                     bus_we3;
    logic [DATA_W-1:0]        bus_wdata3;
    logic [N_SLV3-1:0]        slv_ack3;
    logic [N_SLV3*DATA_W-1:0] slv_rdata3;
    logic [7:0]               err_cnt3;

    ts_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .N_SLV(N_SLV), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_status(rsp_status), .bus_adrs(bus_adrs), .bus_sel(bus_sel),
        .bus_we(bus_we), .bus_wdata(bus_wdata), .slv_ack(slv_ack), .slv_rdata(slv_rdata), .err_cnt(err_cnt)
    );

    ts_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .N_SLV(N_SLV3), .TIMEOUT(TIMEOUT)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
        .req_addr(req_addr3), .req_wdata(req_wdata3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_rdata(rsp_rdata3), .rsp_status(rsp_status3), .bus_adrs(bus_adrs3), .bus_sel(bus_sel3),
        .bus_we(bus_we3), .bus_wdata(bus_wdata3), .slv_ack(slv_ack3), .slv_rdata(slv_rdata3), .err_cnt(err_cnt3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                ack_delay;   // BUS cycle (1-based) in which the target acks
        logic [DATA_W-1:0] sdata;       // target slave's read data
        int                ready_delay; // cycles rsp_ready is held low in RESP
        logic              stray;       // non-selected slaves ack randomly
        int                exp_status;
        logic [DATA_W-1:0] exp_rdata;
        int                exp_lat;     // cycles from accept edge to rsp_valid
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;
    vec_t dir_vec [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: status, data and latency follow directly from address, ack cycle and timeout
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   idx;
        r   = v;
        idx = int'(v.addr) / (2 ** (ADDR_W - SEL_W));
        if (idx >= N_SLV) begin
            r.exp_status = 1; r.exp_rdata = '0; r.exp_lat = 1;
        end else if (v.ack_delay <= TIMEOUT + 1) begin
            r.exp_status = 0; r.exp_rdata = v.write ? '0 : v.sdata; r.exp_lat = v.ack_delay + 1;
        end else begin
            r.exp_status = 2; r.exp_rdata = '0; r.exp_lat = TIMEOUT + 2;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        logic [N_SLV-1:0] onehot;
        int idx;
        idx    = int'(v.addr) / (2 ** (ADDR_W - SEL_W));
        onehot = (idx < N_SLV) ? (N_SLV'(1) << idx) : '0;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < N_SLV; i++) slv_rdata[i*DATA_W +: DATA_W] = 8'($urandom);
        if (idx < N_SLV) slv_rdata[idx*DATA_W +: DATA_W] = v.sdata;
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        tick;
        req_valid = 1'b0; req_addr = 8'($urandom); req_wdata = 8'($urandom); req_write = 1'($urandom);
        for (int k = 1; k < v.exp_lat; k++) begin
            chk("bus_sel", 32'(bus_sel), 32'(onehot));
            chk("bus_we", {31'd0, bus_we}, {31'd0, v.write});
            chk("bus_adrs", 32'(bus_adrs), 32'(v.addr));
            chk("bus_wdata", 32'(bus_wdata), 32'(v.wdata));
            chk("rsp_valid_bus", {31'd0, rsp_valid}, 32'd0);
            chk("req_ready_bus", {31'd0, req_ready}, 32'd0);
            slv_ack = (k == v.ack_delay) ? onehot : '0;
            if (v.stray) slv_ack = slv_ack | (N_SLV'($urandom) & ~onehot);
            tick;
        end
        slv_ack = '0;
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_status", 32'(rsp_status), 32'(v.exp_status));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
        chk("bus_sel_resp", 32'(bus_sel), 32'd0);
        chk("bus_we_resp", {31'd0, bus_we}, 32'd0);
        chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
        for (int j = 0; j < v.ready_delay; j++) begin
            rsp_ready = 1'b0;
            if (v.stray) slv_ack = N_SLV'($urandom);
            tick;
            chk("rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_status_hold", 32'(rsp_status), 32'(v.exp_status));
            chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(v.exp_rdata));
            chk("req_ready_hold", {31'd0, req_ready}, 32'd0);
        end
        slv_ack   = '0;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        if (v.exp_status != 0 && exp_err < 255) exp_err++;
        chk("rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_done", {31'd0, req_ready}, 32'd1);
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   ecnt3;

        dir_vec[0] = '{1'b0, 8'h50, 8'h00, 1,   8'hA5, 0, 1'b0, 0, 8'hA5, 2};
        dir_vec[1] = '{1'b1, 8'hC3, 8'h3C, 4,   8'h77, 0, 1'b0, 0, 8'h00, 5};
        dir_vec[2] = '{1'b0, 8'h10, 8'h00, 100, 8'h11, 0, 1'b0, 2, 8'h00, 17};
        dir_vec[3] = '{1'b0, 8'h9A, 8'h00, 3,   8'h5E, 5, 1'b1, 0, 8'h5E, 4};
        dir_vec[4] = '{1'b0, 8'h2F, 8'h00, 16,  8'hC1, 0, 1'b0, 0, 8'hC1, 17};
        dir_vec[5] = '{1'b1, 8'h7F, 8'h42, 17,  8'h00, 1, 1'b1, 2, 8'h00, 17};
        dir_vec[6] = '{1'b1, 8'hE0, 8'h99, 1,   8'hFF, 2, 1'b1, 0, 8'h00, 2};

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        slv_ack = '0; slv_rdata = '0;
        req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b0;
        slv_ack3 = '0; slv_rdata3 = '0;
        tick; tick;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) run_txn(dir_vec[i]);

        for (int i = 0; i < 150; i++) begin
            v.write = 1'($urandom); v.addr = 8'($urandom); v.wdata = 8'($urandom);
            v.ack_delay = $urandom_range(1, 20); v.sdata = 8'($urandom);
            v.ready_delay = $urandom_range(0, 3); v.stray = 1'($urandom);
            run_txn(model(v));
        end

        // Drive enough timeouts to reach and hold err_cnt saturation
        for (int i = 0; i < 250; i++) begin
            v.write = 1'($urandom); v.addr = 8'($urandom); v.wdata = 8'($urandom);
            v.ack_delay = 100; v.sdata = 8'($urandom); v.ready_delay = 0; v.stray = 1'b0;
            run_txn(model(v));
        end
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        // Reset while waiting in BUS
        slv_rdata = '0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h50; req_wdata = 8'h5A;
        tick;
        req_valid = 1'b0;
        tick; tick;
        chk("pre_rst_bus_sel", 32'(bus_sel), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("mid_rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("mid_rst_bus_adrs", 32'(bus_adrs), 32'd0);
        chk("mid_rst_bus_wdata", 32'(bus_wdata), 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("mid_rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        exp_err = 0;
        tick;
        rst_n = 1'b1;
        tick;
        run_txn(dir_vec[0]);
        run_txn(dir_vec[2]);

        // Three-slave instance: unmapped indices and one mapped read
        ecnt3 = 0;
        for (int i = 0; i < 2; i++) begin
            req_valid3 = 1'b1; req_addr3 = (i == 0) ? 8'hF0 : 8'hC3;
            tick;
            req_valid3 = 1'b0;
            chk("dec3_rsp_valid", {31'd0, rsp_valid3}, 32'd1);
            chk("dec3_status", 32'(rsp_status3), 32'd1);
            chk("dec3_rdata", 32'(rsp_rdata3), 32'd0);
            chk("dec3_bus_sel", 32'(bus_sel3), 32'd0);
            chk("dec3_req_ready", {31'd0, req_ready3}, 32'd0);
            rsp_ready3 = 1'b1;
            tick;
            rsp_ready3 = 1'b0;
            ecnt3++;
            chk("dec3_err_cnt", 32'(err_cnt3), 32'(ecnt3));
            chk("dec3_req_ready_done", {31'd0, req_ready3}, 32'd1);
        end
        slv_rdata3 = 24'h6D_11_22;
        req_valid3 = 1'b1; req_write3 = 1'b0; req_addr3 = 8'h80;
        tick;
        req_valid3 = 1'b0;
        chk("map3_bus_sel", 32'(bus_sel3), 32'h4);
        slv_ack3 = 3'b100;
        tick;
        slv_ack3 = 3'b000;
        chk("map3_rsp_valid", {31'd0, rsp_valid3}, 32'd1);
        chk("map3_status", 32'(rsp_status3), 32'd0);
        chk("map3_rdata", 32'(rsp_rdata3), 32'h6D);
        rsp_ready3 = 1'b1;
        tick;
        rsp_ready3 = 1'b0;
        chk("map3_err_cnt", 32'(err_cnt3), 32'(ecnt3));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ts_bus_ctrl.md
# ts_bus_ctrl

Parametrised, clocked master for the shared addressed slave bus, replacing the fixed-width tri-state master/slave pairing with a muxed, handshaked bus that can be synthesised. It accepts one read or write request at a time and decodes the address to one of `N_SLV` slaves. It waits for that slave's acknowledge, with a timeout, and returns a response carrying data and a status code. It sits between the requesting logic and up to `N_SLV` address-mapped slave blocks.

## Interface
Parameters:
- `ADDR_W`, 8, bus address width.
- `DATA_W`, 8, data width.
- `SEL_W`, 2, number of upper address bits that form the slave index; must satisfy `SEL_W <= ADDR_W`.
- `N_SLV`, 4, number of attached slaves; must satisfy `1 <= N_SLV <= 2**SEL_W`.
- `TIMEOUT`, 15, wait cycles without acknowledge before abort; `TIMEOUT >= 1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors.
- `rsp_status`  out  2  response status: 0 OK, 1 DECERR, 2 TIMEOUT.
- `bus_adrs`  out  ADDR_W  address driven to all slaves.
- `bus_sel`  out  N_SLV  one-hot slave select.
- `bus_we`  out  1  write strobe, qualified by `bus_sel`.
- `bus_wdata`  out  DATA_W  write data to slaves.
- `slv_ack`  in  N_SLV  per-slave acknowledge.
- `slv_rdata`  in  N_SLV*DATA_W  per-slave read data; slave i occupies bits `[i*DATA_W +: DATA_W]`.
- `err_cnt`  out  8  saturating count of non-OK responses.

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch address, write flag and write data, and compute `idx = req_addr[ADDR_W-1 -: SEL_W]`.
  - If `idx < N_SLV`, go to BUS.
  - Otherwise set status DECERR and go directly to RESP. `bus_sel` is never asserted for a DECERR request.
- BUS:
  - `bus_sel[idx]`=1, `bus_adrs`/`bus_we`/`bus_wdata` held from the latched request, wait counter starts at 0.
  - If `slv_ack[idx]`=1: capture `slv_rdata` slice `idx` (reads only; writes capture 0), set status OK, go to RESP.
  - Else increment the counter. When the counter reaches `TIMEOUT`, set status TIMEOUT, `rsp_rdata`=0, go to RESP.
  - Acks from non-selected slaves are ignored.
- RESP:
  - `rsp_valid`=1; `rsp_rdata` and `rsp_status` are held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE. If status is non-OK, `err_cnt` increments, saturating at 255.
- `req_ready`=0 in BUS and RESP. A new request is taken no earlier than the cycle after the response handshake.
- `bus_sel`=0 and `bus_we`=0 outside BUS. `bus_adrs` and `bus_wdata` keep their last value.

## Timing
- Reset (async assert, sync release): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_status`=0, `bus_sel`=0, `bus_we`=0, `bus_adrs`=0, `bus_wdata`=0, `err_cnt`=0, wait counter 0.
- Reset mid-transaction aborts the transaction. No response is produced and `bus_sel` drops immediately.
- Request accepted at edge T. `bus_sel` is asserted in cycle T+1.
- An ack sampled at the end of cycle T+k (k≥1) gives `rsp_valid` in cycle T+k+1. The minimum accept-to-response latency is 2 cycles.
- Timeout: with no ack, BUS lasts exactly `TIMEOUT+1` cycles and `rsp_valid` is asserted in cycle T+`TIMEOUT`+2.
- An ack arriving in the same cycle the counter reaches `TIMEOUT` wins, giving status OK.
- DECERR: `rsp_valid` in cycle T+1.
- Back-to-back throughput: one transaction per 3 cycles minimum when `rsp_ready` is held high.

## Structure
- Package `ts_bus_pkg` holds:
  - state enum `ts_bus_state_e` {IDLE, BUS, RESP};
  - status enum `ts_bus_status_e` {TS_OK=0, TS_DECERR=1, TS_TIMEOUT=2};
  - localparam `ERR_CNT_W`=8.
- One sub-module, `ts_bus_decode`: combinational address-to-index decode producing a mapped flag and a one-hot select. It is parametrised on `ADDR_W`, `SEL_W` and `N_SLV`.
- Timeout counter width is `$clog2(TIMEOUT+1)`.

## Test plan
- Read hit: `req_addr`=0x50, slave 1 acks in its first BUS cycle with rdata 0xA5 -> `bus_sel`=4'b0010 for one cycle; `rsp_valid` 2 cycles after accept; `rsp_rdata`=0xA5; status OK.
- Write with wait states: `req_addr`=0xC3, `req_wdata`=0x3C, slave 3 acks after 4 cycles -> `bus_we`=1 and `bus_wdata`=0x3C for 4 cycles; status OK; `rsp_rdata`=0.
- Timeout: `TIMEOUT`=15, selected slave never acks -> BUS lasts 16 cycles; status TIMEOUT; `err_cnt`=1.
- Decode error: `N_SLV`=3, `req_addr`=0xF0 -> `bus_sel` stays 0; `rsp_valid` at T+1; status DECERR.
- Backpressure and stray ack: `rsp_ready` held low for 5 cycles, non-selected slaves ack during BUS -> response held stable; stray acks ignored; `req_ready`=0 until the cycle after the handshake.
- Reset in BUS: `rst_n` pulsed low mid-wait -> all outputs at their reset values; `err_cnt`=0; next request completes normally.
